adc128s022_emu: RTL and testbench

//  SPI responder that emulates an ADC128S022 8-channel 12-bit converter on the adc_sclk/adc_css/adc_din/adc_dout pins.

---
 rtl/adc128s022_pkg.sv | 19 +
 rtl/adc_emu_sync.sv | 42 ++++
 rtl/adc128s022_emu.sv | 150 +++++++++++++++
 tb/tb_adc128s022_emu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc128s022_pkg.sv
// adc128s022_pkg
//   Constants and state encoding shared by the ADC128S022 emulator and the
//   ADC master that talks to it. A frame is 16 SCLK cycles: 4 leading zeros
//   then 12 data bits MSB first on DOUT, and a 3-bit channel address on DIN
//   captured on rising edges 3, 4 and 5.
package adc128s022_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_RISE_FIRST = 3;
    localparam int ADDR_W          = 3;
    localparam int DATA_W          = 12;

    // IDLE while chip select is high, ACTIVE while a frame is in progress.
    typedef logic [0:0] emu_state_t;
    localparam emu_state_t ST_IDLE   = 1'b0;
    localparam emu_state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/adc_emu_sync.sv
// adc_emu_sync
//   Brings one asynchronous pin into the clk domain through a STAGES-deep
//   flop chain and flags its edges against a registered copy of the
//   synchronised level. Edge flags are high for exactly one clk.
// Ports:
//   clk, rstn  system clock, synchronous active-low reset
//   d          raw pin
//   q          synchronised level
//   rise, fall single-clk edge flags on q
// Parameters:
//   STAGES     synchroniser depth, must be at least 2
//   RESET_VAL  idle level of the pin, so leaving reset creates no edge
module adc_emu_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_r <= {STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/adc128s022_emu.sv
// adc128s022_emu
//   SPI responder emulating an ADC128S022 (8 channels, 12 bits) for
//   hardware-in-loop and self-test of the current/voltage sense path.
//   Samples come from an 8x12 bank written through ch_wr. All pins are
//   oversampled in the clk domain; nothing is clocked by SCLK.
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   ch_wr/ch_sel/ch_data single-clk bank write strobe, entry, value; no backpressure
//   adc_sclk/adc_css/adc_din  SPI pins from the master (SCLK idles high, CS active-low)
//   adc_dout             serial data to the master
//   frame_done           one-clk pulse when a full 16-bit frame completes
//   conv_ch/conv_data    channel and sample carried by the completed frame
//   state_dbg            current FSM state (ST_IDLE / ST_ACTIVE)
// Configuration:
//   ADC_EMU_RAMP_EN      when defined, each completed frame adds RAMP_STEP to
//                        the converted bank entry (a host write the same clk wins)
// Timing: pin actions land SYNC_STAGES+1 clks after the pin edge, so the SCLK
//   half-period must be at least SYNC_STAGES+2 clks.
module adc128s022_emu
    import adc128s022_pkg::*;
#(
    parameter int                 SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0]  RESET_CH    = 3'd0,
    parameter logic [DATA_W-1:0]  RAMP_STEP   = 12'd1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ch_wr,
    input  logic [ADDR_W-1:0] ch_sel,
    input  logic [DATA_W-1:0] ch_data,
    input  logic              adc_sclk,
    input  logic              adc_css,
    input  logic              adc_din,
    output logic              adc_dout,
    output logic              frame_done,
    output logic [ADDR_W-1:0] conv_ch,
    output logic [DATA_W-1:0] conv_data,
    output emu_state_t        state_dbg
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    logic sclk_q, sclk_rise, sclk_fall;
    logic css_q, css_rise, css_fall;
    logic din_q, din_rise, din_fall;

    adc_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rstn(rstn), .d(adc_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    adc_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_css (
        .clk(clk), .rstn(rstn), .d(adc_css), .q(css_q), .rise(css_rise), .fall(css_fall)
    );
    adc_emu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .rstn(rstn), .d(adc_din), .q(din_q), .rise(din_rise), .fall(din_fall)
    );

    // Levels and edges that the protocol does not need.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_q, css_rise, din_rise, din_fall};

    logic [DATA_W-1:0]     bank [8];
    emu_state_t            state;
    logic [ADDR_W-1:0]     next_ch;
    logic [ADDR_W-1:0]     cur_ch;
    logic [ADDR_W-1:0]     addr_sh;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [DATA_W-1:0]     snap;

    // Sample bank. With the ramp enabled the converted entry advances one
    // clk after frame_done; the host write is ordered last so it wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
`ifdef ADC_EMU_RAMP_EN
            if (frame_done) bank[conv_ch] <= bank[conv_ch] + RAMP_STEP;
`endif
            if (ch_wr) bank[ch_sel] <= ch_data;
        end
    end

    // Frame engine. snap holds the 12-bit value loaded at frame start so the
    // reported conv_data does not depend on how far shreg has shifted, and
    // bank writes during a frame never reach the value in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            next_ch    <= RESET_CH;
            cur_ch     <= '0;
            addr_sh    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            snap       <= '0;
            adc_dout   <= 1'b0;
            frame_done <= 1'b0;
            conv_ch    <= '0;
            conv_data  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (css_fall) begin
                        state    <= ST_ACTIVE;
                        shreg    <= {{LEAD_ZEROS{1'b0}}, bank[next_ch]};
                        snap     <= bank[next_ch];
                        cur_ch   <= next_ch;
                        bit_cnt  <= '0;
                        adc_dout <= 1'b0;
                    end
                end
                default: begin
                    if (css_q) begin
                        // Abort: partial address is dropped, next_ch untouched.
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        adc_dout <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                            adc_dout <= shreg[FRAME_BITS-2];
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            // Rises ADDR_RISE_FIRST.. shift DIN in MSB first.
                            if (bit_cnt >= CNT_W'(ADDR_RISE_FIRST - 1) &&
                                bit_cnt <  CNT_W'(ADDR_RISE_FIRST - 1 + ADDR_W))
                                addr_sh <= {addr_sh[ADDR_W-2:0], din_q};
                            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                // Last rise: report, commit the address and
                                // preload the next frame for back-to-back use.
                                next_ch    <= addr_sh;
                                frame_done <= 1'b1;
                                conv_ch    <= cur_ch;
                                conv_data  <= snap;
                                shreg      <= {{LEAD_ZEROS{1'b0}}, bank[addr_sh]};
                                snap       <= bank[addr_sh];
                                cur_ch     <= addr_sh;
                                adc_dout   <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_adc128s022_emu.sv
// tb_adc128s022_emu
//   Directed bench for adc128s022_emu: drives SPI frames (single frames at
//   half-periods 4 and 8, back-to-back frames with CS held low), aborted
//   frames, mid-frame reset and the optional ramp mode (ADC_EMU_RAMP_EN).
module tb_adc128s022_emu;
    import adc128s022_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ch_wr = 1'b0;
    logic [2:0]  ch_sel = '0;
    logic [11:0] ch_data = '0;
    logic        adc_sclk = 1'b1;
    logic        adc_css = 1'b1;
    logic        adc_din = 1'b0;
    logic        adc_dout;
    logic        frame_done;
    logic [2:0]  conv_ch;
    logic [11:0] conv_data;
    emu_state_t  state_dbg;

    int checks = 0;
    int errors = 0;
    int sclk_rises = 0;

    logic [14:0] got_q[$];
    logic [14:0] exp_q[$];
    int          rise_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    adc128s022_emu dut (
        .clk(clk), .rstn(rstn), .ch_wr(ch_wr), .ch_sel(ch_sel), .ch_data(ch_data),
        .adc_sclk(adc_sclk), .adc_css(adc_css), .adc_din(adc_din), .adc_dout(adc_dout),
        .frame_done(frame_done), .conv_ch(conv_ch), .conv_data(conv_data),
        .state_dbg(state_dbg)
    );

    // Frame monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_done) begin
            got_q.push_back({conv_ch, conv_data});
            rise_q.push_back(sclk_rises);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] ch, input logic [11:0] d);
        ch_wr = 1'b1; ch_sel = ch; ch_data = d;
        tick(1);
        ch_wr = 1'b0;
    endtask

    // One SCLK cycle: sample DOUT while SCLK is high, fall (drive DIN), rise.
    task automatic spi_bit(input int half, input logic din_bit, output logic dout_bit);
        dout_bit = adc_dout;
        adc_sclk = 1'b0;
        adc_din  = din_bit;
        tick(half);
        adc_sclk = 1'b1;
        sclk_rises++;
        tick(half);
    endtask

    // n frames with CS held low; addrs[3f+:3] is the address sent in frame f,
    // words[16f+:16] the 16 DOUT bits received in frame f.
    task automatic spi_frames(input int half, input int n, input logic [11:0] addrs,
                              output logic [63:0] words);
        logic        b;
        logic [15:0] ctl;
        words = '0;
        adc_css = 1'b0;
        tick(half);
        for (int f = 0; f < n; f++) begin
            ctl = {2'b00, addrs[f*3 +: 3], 11'b0};
            for (int i = 0; i < 16; i++) begin
                spi_bit(half, ctl[15-i], b);
                words[f*16 + 15 - i] = b;
            end
        end
        tick(half);
        adc_css = 1'b1;
        tick(2 * half + 4);
    endtask

    task automatic master_frame(input int half, input logic [2:0] addr, output logic [15:0] word);
        logic [63:0] ws;
        spi_frames(half, 1, {9'd0, addr}, ws);
        word = ws[15:0];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rstn = 1'b0;
        tick(4);
        checks++; if (adc_dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %0b exp 0", adc_dout); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", frame_done); end
        checks++; if (conv_ch !== 3'd0) begin errors++; $display("FAIL reset_conv_ch got %0d exp 0", conv_ch); end
        checks++; if (conv_data !== 12'h000) begin errors++; $display("FAIL reset_conv_data got %h exp 000", conv_data); end
        rstn = 1'b1;
        tick(4);
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_single_frame;
        logic [15:0] w;
        logic [14:0] g;
        got_q.delete();
        host_write(3'd0, 12'hA5C);
        master_frame(4, 3'd3, w);
        checks++; if (w !== 16'h0A5C) begin errors++; $display("FAIL t1_dout got %h exp 0a5c", w); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL t1_frame_count got %0d exp 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {3'd0, 12'hA5C}) begin errors++; $display("FAIL t1_conv got ch%0d %h exp ch0 a5c", g[14:12], g[11:0]); end
        end
    endtask

    task automatic test_pipelined_addr;
        logic [15:0] w;
        logic [14:0] g;
        got_q.delete();
        host_write(3'd3, 12'h123);
        master_frame(8, 3'd5, w);
        checks++; if (w !== 16'h0123) begin errors++; $display("FAIL t2_dout_a got %h exp 0123", w); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL t2_count_a got %0d exp 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {3'd3, 12'h123}) begin errors++; $display("FAIL t2_conv_a got ch%0d %h exp ch3 123", g[14:12], g[11:0]); end
        end
        host_write(3'd5, 12'h5A5);
        master_frame(8, 3'd1, w);
        checks++; if (w !== 16'h05A5) begin errors++; $display("FAIL t2_dout_b got %h exp 05a5", w); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL t2_count_b got %0d exp 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {3'd5, 12'h5A5}) begin errors++; $display("FAIL t2_conv_b got ch%0d %h exp ch5 5a5", g[14:12], g[11:0]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ws;
        logic [14:0] e, g;
        got_q.delete(); rise_q.delete(); exp_q.delete();
        host_write(3'd1, 12'h111);
        host_write(3'd4, 12'h444);
        // Frame A addresses ch4 and converts ch1; frame B addresses ch2 and converts ch4.
        spi_frames(6, 2, {6'd0, 3'd2, 3'd4}, ws);
        exp_q.push_back({3'd1, 12'h111});
        exp_q.push_back({3'd4, 12'h444});
        checks++; if (ws[15:0] !== 16'h0111) begin errors++; $display("FAIL t3_dout_a got %h exp 0111", ws[15:0]); end
        checks++; if (ws[31:16] !== 16'h0444) begin errors++; $display("FAIL t3_dout_b got %h exp 0444", ws[31:16]); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t3_frame_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL t3_conv got ch%0d %h exp ch%0d %h", g[14:12], g[11:0], e[14:12], e[11:0]); end
        end
        if (rise_q.size() == 2) begin
            checks++;
            if (rise_q[1] - rise_q[0] != 16) begin errors++; $display("FAIL t3_spacing got %0d exp 16", rise_q[1] - rise_q[0]); end
        end
    endtask

    task automatic test_abort;
        logic        b;
        logic [15:0] ctl, w;
        logic [14:0] g;
        got_q.delete();
        host_write(3'd2, 12'h2DF);
        host_write(3'd6, 12'h666);
        ctl = {2'b00, 3'd6, 11'b0};
        adc_css = 1'b0;
        tick(4);
        for (int i = 0; i < 9; i++) spi_bit(4, ctl[15-i], b);
        // After 9 falls DOUT carries DB6 of 0x2DF, which is 1.
        checks++; if (adc_dout !== 1'b1) begin errors++; $display("FAIL t4_dout_mid got %0b exp 1", adc_dout); end
        adc_css = 1'b1;
        tick(12);
        checks++; if (adc_dout !== 1'b0) begin errors++; $display("FAIL t4_dout_abort got %0b exp 0", adc_dout); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL t4_no_frame got %0d exp 0", got_q.size()); end
        got_q.delete();
        master_frame(4, 3'd7, w);
        checks++; if (w !== 16'h02DF) begin errors++; $display("FAIL t4_dout_next got %h exp 02df", w); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL t4_count got %0d exp 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {3'd2, 12'h2DF}) begin errors++; $display("FAIL t4_conv got ch%0d %h exp ch2 2df", g[14:12], g[11:0]); end
        end
    endtask

    task automatic test_mid_reset;
        logic        b;
        logic [15:0] w;
        logic [14:0] g;
        host_write(3'd7, 12'hFFF);
        adc_css = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++) spi_bit(4, 1'b0, b);
        checks++; if (adc_dout !== 1'b1) begin errors++; $display("FAIL t5_dout_pre got %0b exp 1", adc_dout); end
        rstn = 1'b0; adc_css = 1'b1; adc_sclk = 1'b1;
        tick(2);
        checks++; if (adc_dout !== 1'b0) begin errors++; $display("FAIL t5_dout got %0b exp 0", adc_dout); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL t5_frame_done got %0b exp 0", frame_done); end
        checks++; if (conv_data !== 12'h000) begin errors++; $display("FAIL t5_conv_data got %h exp 000", conv_data); end
        rstn = 1'b1;
        tick(6);
        got_q.delete();
        master_frame(4, 3'd2, w);
        checks++; if (w !== 16'h0000) begin errors++; $display("FAIL t5_dout_after got %h exp 0000", w); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL t5_count got %0d exp 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {3'd0, 12'h000}) begin errors++; $display("FAIL t5_conv got ch%0d %h exp ch0 000", g[14:12], g[11:0]); end
        end
    endtask

    task automatic test_ramp;
        logic [15:0] w;
        logic [11:0] exp_v [3];
        logic [14:0] g;
`ifdef ADC_EMU_RAMP_EN
        exp_v[0] = 12'hFFF; exp_v[1] = 12'h000; exp_v[2] = 12'h001;
`else
        exp_v[0] = 12'hFFF; exp_v[1] = 12'hFFF; exp_v[2] = 12'hFFF;
`endif
        host_write(3'd2, 12'hFFF);
        for (int k = 0; k < 3; k++) begin
            got_q.delete();
            master_frame(4, 3'd2, w);
            checks++;
            if (w !== {4'h0, exp_v[k]}) begin errors++; $display("FAIL t6_dout_%0d got %h exp %h", k, w, {4'h0, exp_v[k]}); end
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL t6_count_%0d got %0d exp 1", k, got_q.size());
            end else begin
                g = got_q.pop_front();
                if (g !== {3'd2, exp_v[k]}) begin errors++; $display("FAIL t6_conv_%0d got ch%0d %h exp ch2 %h", k, g[14:12], g[11:0], exp_v[k]); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tick(1);
        test_reset();
        test_single_frame();
        test_pipelined_addr();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
